// File: rtl/gray_decode_checker.sv
// -----------------------------------------------------------------------------
// gray_decode_checker
//
// Receive-side checker for a gray-coded counter. Each enabled sample of
// gray_in is converted to binary and compared against the previous accepted
// value plus one (modulo 2^WIDTH). Legal steps keep the checker locked. A bad
// step pulses step_err, bumps a saturating error counter and drops lock. The
// next enabled sample re-acquires lock.
//
// Optional feature macro: GRAY_DEC_HOLD_EN
//   When defined, a sample equal to the reference while tracking is a legal
//   hold. valid pulses, and bin_out, the reference and lock are unchanged.
//   When undefined, such a sample is a step error.
//
// Parameters:
//   WIDTH      width of gray_in / bin_out (2..16)
//   ERR_W      width of err_count
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset of all state
//   enable     sample qualifier for gray_in
//   gray_in    gray-coded count under check
//   bin_out    registered binary value of the last sample
//   valid      one-cycle pulse, bin_out updated this cycle
//   locked     high while a trusted reference value is held
//   step_err   one-cycle pulse, the last sample broke the +1 sequence
//   err_count  saturating count of step errors
// -----------------------------------------------------------------------------
module gray_decode_checker #(
    parameter int WIDTH = 5,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out,
    output logic             valid,
    output logic             locked,
    output logic             step_err,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        TRACK    = 1'b1
    } state_t;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t           state_q;
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] bin_q;
    logic             valid_q;
    logic             locked_q;
    logic             step_err_q;
    logic [ERR_W-1:0] err_q;

    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] exp_d;
    logic             is_hold;

    // Binary bit i is the XOR of all gray bits at positions i and above.
    always_comb begin
        // NOTE: every always_comb output gets a default before any
        // conditional or looped assignment, so no latch can be inferred.
        bin_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_d[i] = ^(gray_in >> i);
        end
    end

    // Natural WIDTH-bit wrap makes all-ones followed by zero a legal step.
    assign exp_d = ref_q + WIDTH'(1);

`ifdef GRAY_DEC_HOLD_EN
    assign is_hold = (bin_d == ref_q);
`else
    assign is_hold = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= UNLOCKED;
            ref_q      <= '0;
            bin_q      <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            step_err_q <= 1'b0;
            err_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // sees pre-edge values regardless of statement order.
            valid_q    <= 1'b0;
            step_err_q <= 1'b0;
            if (enable) begin
                case (state_q)
                    UNLOCKED: begin
                        // Acquire: any sample becomes the new reference.
                        ref_q    <= bin_d;
                        bin_q    <= bin_d;
                        valid_q  <= 1'b1;
                        locked_q <= 1'b1;
                        state_q  <= TRACK;
                    end
                    TRACK: begin
                        valid_q <= 1'b1;
                        if (bin_d == exp_d) begin
                            ref_q <= bin_d;
                            bin_q <= bin_d;
                        end else if (!is_hold) begin
                            // The bad sample is reported, not adopted as the
                            // reference; the next sample re-acquires.
                            bin_q      <= bin_d;
                            step_err_q <= 1'b1;
                            locked_q   <= 1'b0;
                            state_q    <= UNLOCKED;
                            if (err_q != ERR_MAX) begin
                                err_q <= err_q + ERR_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q  <= UNLOCKED;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bin_out   = bin_q;
    assign valid     = valid_q;
    assign locked    = locked_q;
    assign step_err  = step_err_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_gray_decode_checker.sv
// -----------------------------------------------------------------------------
// tb_gray_decode_checker
//
// Directed bench for gray_decode_checker (WIDTH=5, ERR_W=8). A reference model
// built on a gray-to-binary lookup table predicts every output. A compare
// process checks the DUT against it on every falling edge. Literal checks
// after key samples pin the model itself. Honours GRAY_DEC_HOLD_EN like the
// design does.
// -----------------------------------------------------------------------------
module tb_gray_decode_checker;

    localparam int W       = 5;
    localparam int EW      = 8;
    localparam int N       = 1 << W;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [W-1:0]  gray_in = '0;
    logic [W-1:0]  bin_out;
    logic          valid;
    logic          locked;
    logic          step_err;
    logic [EW-1:0] err_count;

    int total = 0;
    int bad   = 0;

    gray_decode_checker #(.WIDTH(W), .ERR_W(EW)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .gray_in   (gray_in),
        .bin_out   (bin_out),
        .valid     (valid),
        .locked    (locked),
        .step_err  (step_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] gray(input int v);
        gray = W'(v ^ (v >> 1));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Inverse of the gray encoding as a table, filled from the forward map.
    int inv [N];
    initial begin
        for (int v = 0; v < N; v++) inv[gray(v)] = v;
    end

    int m_ref, m_bin, m_err, b;
    bit m_lock, m_valid, m_serr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ref = 0; m_bin = 0; m_err = 0;
            m_lock = 0; m_valid = 0; m_serr = 0;
        end else begin
            m_valid = 0;
            m_serr  = 0;
            if (enable) begin
                b = inv[gray_in];
                m_valid = 1;
                if (!m_lock) begin
                    m_ref = b; m_bin = b; m_lock = 1;
                end else if (b == (m_ref + 1) % N) begin
                    m_ref = b; m_bin = b;
`ifdef GRAY_DEC_HOLD_EN
                end else if (b == m_ref) begin
                    // legal hold: nothing changes
`endif
                end else begin
                    m_bin  = b;
                    m_serr = 1;
                    m_lock = 0;
                    if (m_err < ERR_MAX) m_err++;
                end
            end
        end
    end

    // Continuous comparison away from the active edge.
    always @(negedge clk) begin
        check("cmp_bin_out",   int'(bin_out),   m_bin);
        check("cmp_valid",     int'(valid),     int'(m_valid));
        check("cmp_locked",    int'(locked),    int'(m_lock));
        check("cmp_step_err",  int'(step_err),  int'(m_serr));
        check("cmp_err_count", int'(err_count), m_err);
    end

    // ---------------- stimulus ----------------
    task automatic sample(input logic en, input logic [W-1:0] g);
        @(negedge clk);
        enable  = en;
        gray_in = g;
        @(posedge clk);
        #1;
    endtask

    task automatic smp(input int v);
        sample(1'b1, gray(v));
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_bin_out", int'(bin_out), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_step_err", int'(step_err), 0);
        check("rst_err_count", int'(err_count), 0);

        // 40-cycle legal sequence with wrap
        for (int i = 0; i < 40; i++) begin
            smp(i % N);
            if (i == 0) begin
                check("seq_first_locked", int'(locked), 1);
                check("seq_first_valid", int'(valid), 1);
                check("seq_first_err", int'(step_err), 0);
            end
            if (i == 31) check("seq_bin_31", int'(bin_out), 31);
            if (i == 32) begin
                check("seq_wrap_bin", int'(bin_out), 0);
                check("seq_wrap_err", int'(step_err), 0);
            end
        end
        check("seq_end_bin", int'(bin_out), 7);
        check("seq_end_errcnt", int'(err_count), 0);

        // Bad step from 10 to 12, then re-lock on 13
        smp(8); smp(9); smp(10);
        smp(12);
        check("bad_bin", int'(bin_out), 12);
        check("bad_step_err", int'(step_err), 1);
        check("bad_errcnt", int'(err_count), 1);
        check("bad_locked", int'(locked), 0);
        smp(13);
        check("relock_locked", int'(locked), 1);
        check("relock_step_err", int'(step_err), 0);
        check("relock_bin", int'(bin_out), 13);

        // Lock at 5 (via one more error), then an enable gap with junk
        smp(20);
        smp(5);
        check("gap_pre_locked", int'(locked), 1);
        for (int i = 0; i < 10; i++) begin
            sample(1'b0, W'($urandom_range(0, N - 1)));
            check("gap_valid", int'(valid), 0);
            check("gap_bin", int'(bin_out), 5);
        end
        smp(6);
        check("gap_resume_bin", int'(bin_out), 6);
        check("gap_resume_err", int'(step_err), 0);
        check("gap_resume_errcnt", int'(err_count), 2);

        // Lock at 20 with err_count=3, then asynchronous reset mid-cycle
        smp(1);
        smp(20);
        check("pre_rst_bin", int'(bin_out), 20);
        check("pre_rst_errcnt", int'(err_count), 3);
        @(negedge clk);
        enable  = 1'b1;
        gray_in = gray(3);
        #2 reset = 1'b1;
        #1;
        check("async_rst_bin", int'(bin_out), 0);
        check("async_rst_locked", int'(locked), 0);
        check("async_rst_valid", int'(valid), 0);
        check("async_rst_errcnt", int'(err_count), 0);
        @(posedge clk);
        #1;
        check("rst_wins_valid", int'(valid), 0);
        check("rst_wins_locked", int'(locked), 0);
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        smp(9);
        check("post_rst_locked", int'(locked), 1);
        check("post_rst_step_err", int'(step_err), 0);
        check("post_rst_bin", int'(bin_out), 9);

        // Repeated sample of 9
        smp(9);
        check("hold_valid", int'(valid), 1);
        check("hold_bin", int'(bin_out), 9);
`ifdef GRAY_DEC_HOLD_EN
        check("hold_step_err", int'(step_err), 0);
        check("hold_locked", int'(locked), 1);
        check("hold_errcnt", int'(err_count), 0);
`else
        check("hold_step_err", int'(step_err), 1);
        check("hold_locked", int'(locked), 0);
        check("hold_errcnt", int'(err_count), 1);
`endif

        // 300 bad steps, each preceded by a re-acquire sample
        for (int i = 0; i < 300; i++) begin
            smp(0);
            smp(5);
            check("sat_step_err", int'(step_err), 1);
        end
        check("sat_errcnt", int'(err_count), ERR_MAX);
        smp(0);
        smp(7);
        check("sat_no_wrap", int'(err_count), ERR_MAX);

        sample(1'b0, '0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_decode_checker.md
# gray_decode_checker

Receive-side companion to the 5-bit gray-code counter. Samples a gray-coded count bus, converts each sample to binary, and checks that consecutive samples form a legal +1 sequence, including the wrap from all-ones to zero. Reports lock status, per-sample step errors and a saturating error count, so the bench and downstream logic can trust or reject the counter stream.

## Interface
- WIDTH, 5, width of the gray input and binary output; legal range 2..16.
- ERR_W, 8, width of the error counter.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- enable  input  1  sample qualifier; gray_in is sampled only when high at a rising edge.
- gray_in  input  WIDTH  gray-coded count from the counter under check.
- bin_out  output  WIDTH  registered binary value of the last sample.
- valid  output  1  one-cycle pulse: bin_out updated this cycle.
- locked  output  1  high while the checker holds a trusted reference value.
- step_err  output  1  one-cycle pulse: the last sample broke the +1 sequence.
- err_count  output  ERR_W  saturating count of step errors.

## Operation
- Conversion: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i] for i = WIDTH-2 down to 0.
- The reference register `ref` holds the binary value of the last accepted sample.
- Expected value: exp = (ref + 1) mod 2^WIDTH, so 2^WIDTH-1 followed by 0 is legal.
- FSM states: UNLOCKED (reset state) and TRACK.
- UNLOCKED, enable=1: ref <= b, bin_out <= b, valid=1, locked=1 next cycle, move to TRACK; step_err=0.
- TRACK, enable=1, b == exp: ref <= b, bin_out <= b, valid=1, stay in TRACK.
- TRACK, enable=1, b != exp (and not a hold, see Configuration): bin_out <= b, valid=1, step_err=1, err_count increments unless at 2^ERR_W-1, locked=0, move to UNLOCKED. The erroring sample is not adopted as the reference; the next enabled sample re-acquires lock.
- enable=0 in any state: no sample is taken; bin_out, ref, locked and err_count hold; valid=0; step_err=0.
- err_count saturates at all-ones and never wraps. It is cleared only by reset.

## Timing
- Latency: gray_in sampled at edge N; bin_out, valid, step_err and locked reflect it after edge N (1 cycle).
- valid and step_err are single-cycle pulses. They re-assert on consecutive cycles when enable stays high.
- Reset values: bin_out=0, valid=0, locked=0, step_err=0, err_count=0, ref=0, state=UNLOCKED.
- Reset mid-stream clears all state asynchronously, without waiting for clk. On the first enabled edge after deassertion the checker acquires lock; it never flags an error on that edge.
- reset high together with enable high: reset wins and nothing is sampled.
- Deasserting enable for any number of cycles does not break lock. The sequence check resumes from ref.

## Configuration
- GRAY_DEC_HOLD_EN defined: in TRACK, an enabled sample with b == ref is a legal hold.
  - Response: valid=1, bin_out unchanged, no step_err, ref unchanged, state stays TRACK.
  - This covers a counter that presents a stable output while enabled.
- GRAY_DEC_HOLD_EN undefined: b == ref in TRACK is treated as a step error, following the mismatch rule above.

## Test plan
- Reset, then enable for 40 cycles with gray_in = 0,1,3,2,6,…,16 (binary 0..31, wrapping to 0..7) -> locked=1 after the first sample, bin_out tracks 0..31,0..7, step_err never asserts, err_count=0.
- Locked at binary 10, drive gray of 12 (0x0A) -> bin_out=12, step_err pulses once, err_count=1, locked=0. Next sample gray of 13 -> re-lock with no error.
- Force 300 consecutive bad steps -> err_count stops at 255 and does not wrap.
- Locked at binary 5, enable=0 for 10 cycles with gray_in at junk values, then enable with gray of 6 -> valid=0 during the gap, no error, bin_out=6.
- Assert reset asynchronously between clock edges while locked at 20 with err_count=3 -> all outputs go to 0 before the next edge. The first enabled sample afterwards locks cleanly.
- Two consecutive enabled samples of gray of 9 -> with GRAY_DEC_HOLD_EN: no step_err, locked stays 1. Without it: step_err pulses, err_count increments.
